// File: rtl/serial_comp.sv
// Digit-serial magnitude comparator: examines DIGIT bits per cycle from the MSB
// and stops at the first differing digit. Signed compares flip both MSBs.
module serial_comp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     x,
    input  logic [WIDTH-1:0]                     y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 xly,
    output logic                                 xgy,
    output logic                                 xey,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]     ndig
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int NW   = $clog2(NDIG + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;

    logic [WIDTH-1:0] xr, yr, xs, ys;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] xd, yd;
    logic             load, last, decide;

    assign load   = start && (state != RUN);
    // Shift the current digit up to the MSB end so one fixed slice reads it.
    assign xs     = xr << (int'(idx) * DIGIT);
    assign ys     = yr << (int'(idx) * DIGIT);
    assign xd     = xs[WIDTH-1 -: DIGIT];
    assign yd     = ys[WIDTH-1 -: DIGIT];
    assign last   = (idx == IW'(NDIG - 1));
    assign decide = (xd != yd) || last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (decide) nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xly  <= 1'b0;
            xgy  <= 1'b0;
            xey  <= 1'b0;
            ndig <= '0;
        end else if (load) begin
            // Offset-binary in signed mode turns the rest into an unsigned compare.
            xr  <= {x[WIDTH-1] ^ signed_mode, x[WIDTH-2:0]};
            yr  <= {y[WIDTH-1] ^ signed_mode, y[WIDTH-2:0]};
            idx <= '0;
        end else if (state == RUN) begin
            idx <= idx + IW'(1);
            if (decide) begin
                xly  <= (xd < yd);
                xgy  <= (xd > yd);
                xey  <= (xd == yd);
                ndig <= NW'(idx) + NW'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_comp.sv
// Scoreboard bench for serial_comp: an 8-bit/2-bit instance with directed and
// random traffic, plus exhaustive 4-bit instances for DIGIT = 1, 2 and 4.
module tb_serial_comp;
    typedef struct {
        bit lt;
        bit gt;
        bit eq;
        int nd;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: relation from plain (signed) integer compare; digit count from
    // the first differing DIGIT-wide group of the offset-binary values.
    function automatic exp_t model(input int w, input int d, input int a, input int b, input bit m);
        exp_t e;
        int ao, bo, sa, sb, da, db;
        bit found;
        ao = a; bo = b; sa = a; sb = b;
        if (m) begin
            ao = a ^ (1 << (w - 1));
            bo = b ^ (1 << (w - 1));
            if (a >= (1 << (w - 1))) sa = a - (1 << w);
            if (b >= (1 << (w - 1))) sb = b - (1 << w);
        end
        e.lt = (sa < sb);
        e.gt = (sa > sb);
        e.eq = (sa == sb);
        e.nd = w / d;
        e.t0 = 0;
        found = 0;
        for (int i = 0; i < w / d; i++) begin
            da = (ao >> (w - (i + 1) * d)) % (1 << d);
            db = (bo >> (w - (i + 1) * d)) % (1 << d);
            if (!found && da != db) begin
                e.nd = i + 1;
                found = 1;
            end
        end
        return e;
    endfunction

    // ---------------- main 8-bit / 2-bit instance ----------------
    logic       start = 1'b0, sm = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       busy, done, xly, xgy, xey;
    logic [2:0] ndig;
    exp_t       q[$];

    serial_comp #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .x(x), .y(y),
        .busy(busy), .done(done), .xly(xly), .xgy(xgy), .xey(xey), .ndig(ndig)
    );

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("xly", xly, e.lt);
                chk("xgy", xgy, e.gt);
                chk("xey", xey, e.eq);
                chk("ndig", ndig, e.nd);
                chk("latency", cyc - e.t0, e.nd + 1);
                chk("onehot", xly + xgy + xey, 1);
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit m, input bit push);
        int w = 0;
        exp_t e;
        while (busy && w < 50) begin @(posedge clk); #1; w++; end
        if (w >= 50) chk("issue_timeout", 0, 1);
        x = a; y = b; sm = m; start = 1'b1;
        if (push) begin
            e = model(8, 2, a, b, m);
            e.t0 = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [7:0] a, input logic [7:0] b, input bit m,
                           input bit lt, input bit gt, input bit eq, input int nd);
        int lat = 1;
        issue(a, b, m, 1);
        while (!done && lat < 40) begin
            chk({name, "_busy"}, busy, 1);
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, nd + 1);
        chk({name, "_busy_at_done"}, busy, 0);
        chk({name, "_xly"}, xly, lt);
        chk({name, "_xgy"}, xgy, gt);
        chk({name, "_xey"}, xey, eq);
        chk({name, "_ndig"}, ndig, nd);
    endtask

    // ---------------- exhaustive 4-bit instances ----------------
    for (genvar g = 0; g < 3; g++) begin : sg
        localparam int DG = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int NW = $clog2(4 / DG + 1);
        logic          st = 1'b0, m = 1'b0;
        logic [3:0]    a = '0, b = '0;
        logic          bs, dn, lt, gt, eq;
        logic [NW-1:0] nd;
        exp_t          sq[$];
        bit            fin = 0;

        serial_comp #(.WIDTH(4), .DIGIT(DG)) u (
            .clk(clk), .rst(rst_s), .start(st), .signed_mode(m), .x(a), .y(b),
            .busy(bs), .done(dn), .xly(lt), .xgy(gt), .xey(eq), .ndig(nd)
        );

        initial begin
            exp_t e;
            int w;
            wait (!rst_s);
            @(posedge clk); #1;
            for (int mm = 0; mm < 2; mm++) begin
                for (int i = 0; i < 256; i++) begin
                    w = 0;
                    while (bs && w < 50) begin @(posedge clk); #1; w++; end
                    if (w >= 50) chk("small_timeout", 0, 1);
                    a = i[7:4]; b = i[3:0]; m = mm[0]; st = 1'b1;
                    e = model(4, DG, i >> 4, i & 15, mm[0]);
                    e.t0 = cyc;
                    sq.push_back(e);
                    @(posedge clk); #1;
                    st = 1'b0;
                end
            end
            fin = 1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (!rst_s && dn) begin
                if (sq.size() == 0) chk("w4_spurious_done", 1, 0);
                else begin
                    e = sq.pop_front();
                    chk("w4_xly", lt, e.lt);
                    chk("w4_xgy", gt, e.gt);
                    chk("w4_xey", eq, e.eq);
                    chk("w4_ndig", nd, e.nd);
                    chk("w4_latency", cyc - e.t0, e.nd + 1);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        exp_t e;
        int   w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {xly, xgy, xey}, 0);
        chk("rst_ndig", ndig, 0);
        rst = 1'b0; rst_s = 1'b0;
        @(posedge clk); #1;

        run_dir("early_exit", 8'hA5, 8'h35, 1'b0, 0, 1, 0, 1);
        run_dir("equal",      8'h3C, 8'h3C, 1'b0, 0, 0, 1, 4);
        run_dir("sgn_80_01",  8'h80, 8'h01, 1'b1, 1, 0, 0, 1);
        run_dir("uns_80_01",  8'h80, 8'h01, 1'b0, 0, 1, 0, 1);
        run_dir("sgn_ff_fe",  8'hFF, 8'hFE, 1'b1, 0, 1, 0, 4);
        // Issued in the DONE cycle of the previous compare: no idle bubble.
        run_dir("b2b",        8'h12, 8'h13, 1'b0, 1, 0, 0, 4);

        // Random traffic: start often held through RUN while operands churn.
        for (int c = 0; c < 800; c++) begin
            x     = 8'($urandom);
            y     = ($urandom % 4 == 0) ? x : (($urandom % 2 == 1) ? (x ^ 8'(1 << ($urandom % 8))) : 8'($urandom));
            sm    = 1'($urandom);
            start = ($urandom % 4 != 0);
            if (start && !busy) begin
                e = model(8, 2, x, y, sm);
                e.t0 = cyc;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        w = 0;
        while ((busy || done) && w < 50) begin @(posedge clk); #1; w++; end
        if (w >= 50) chk("drain_timeout", 0, 1);

        // Reset two cycles into a 4-digit compare.
        issue(8'h3C, 8'h3D, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flags", {xly, xgy, xey}, 0);
        chk("midrst_ndig", ndig, 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("postrst_flags", {xly, xgy, xey}, 0);
        run_dir("after_rst", 8'h35, 8'hA5, 1'b0, 1, 0, 0, 1);

        w = 0;
        while (!(sg[0].fin && sg[1].fin && sg[2].fin) && w < 20000) begin @(posedge clk); w++; end
        if (w >= 20000) chk("w4_finish_timeout", 0, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("main_queue_empty", q.size(), 0);
        chk("w4d1_queue_empty", sg[0].sq.size(), 0);
        chk("w4d2_queue_empty", sg[1].sq.size(), 0);
        chk("w4d4_queue_empty", sg[2].sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_comp.md
SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be at least 2.
REQ-002 Parameter DIGIT, default 2, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be between 1 and WIDTH.
REQ-003 Derived constant: NDIG = WIDTH/DIGIT, the number of digits per operand.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request a compare; sampled only when busy=0.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare; sampled with start.
REQ-009 x  input  WIDTH  operand X; sampled with start.
REQ-010 y  input  WIDTH  operand Y; sampled with start.
REQ-011 busy  output  1  high while a compare is in progress (RUN state).
REQ-012 done  output  1  one-cycle pulse marking the cycle in which a new result is first valid.
REQ-013 xly  output  1  registered result flag: X < Y.
REQ-014 xgy  output  1  registered result flag: X > Y.
REQ-015 xey  output  1  registered result flag: X == Y.
REQ-016 ndig  output  $clog2(NDIG+1)  number of digits examined for the last result, in the range 1..NDIG.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE on the deciding digit (REQ-021).
- DONE -> RUN when start=1; otherwise DONE -> IDLE.
REQ-018 When start=1 in IDLE or DONE, the block SHALL latch x, y and signed_mode and set the digit index to 0 (MSB digit).
- In signed mode the latched MSB of both x and y SHALL be inverted (offset-binary), so the remaining compare is unsigned.
REQ-019 start SHALL be ignored in RUN.
- x, y and signed_mode changes during RUN SHALL NOT affect the result.
REQ-020 In each RUN cycle the block SHALL compare latched digit [WIDTH-1-i*DIGIT -: DIGIT] of X and Y, where i is the digit index, then increment i.
REQ-021 A RUN cycle is the deciding digit if its digits differ or i = NDIG-1.
- On the deciding digit's clock edge, xly/xgy/xey and ndig = i+1 SHALL be updated and the state SHALL go to DONE.
REQ-022 Early termination: the block SHALL stop at the first differing digit; no further digits are examined.
REQ-023 Latency: with start sampled in cycle n and k digits examined, busy=1 in cycles n+1..n+k and done=1 in cycle n+k+1 only.
- Bounds: 1 <= k <= NDIG.
- Back-to-back: a start accepted in the DONE cycle gives a new RUN from the next cycle, with no idle bubble.
REQ-024 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-025 After the first completed compare, exactly one of xly/xgy/xey SHALL be 1.
- Result flags and ndig SHALL hold their value until the next deciding digit or reset.
REQ-026 Equal operands SHALL always take k = NDIG cycles and give xey=1.
REQ-027 When DIGIT = WIDTH, every compare SHALL take exactly one RUN cycle.

Reset
REQ-028 When rst=1 at a clock edge, the next state SHALL be IDLE, and busy, done, xly, xgy, xey and ndig SHALL all be 0.
REQ-029 rst SHALL override start in the same cycle.
REQ-030 A reset during RUN SHALL abandon the compare: no done pulse follows, and the result flags read 0 until a new compare completes.
REQ-031 The latched operand registers need not be reset.

Verification (WIDTH=8, DIGIT=2 unless stated; start sampled in cycle n)
REQ-032 Unsigned, early exit: x=8'hA5, y=8'h35, signed_mode=0.
- Required: busy in cycle n+1 only; done in cycle n+2.
- Result: xgy=1, xly=0, xey=0, ndig=1.
REQ-033 Equal operands: x=y=8'h3C.
- Required: busy in cycles n+1..n+4; done in cycle n+5.
- Result: xey=1, ndig=4.
REQ-034 Sign mode: x=8'h80, y=8'h01.
- With signed_mode=1: xly=1, ndig=1.
- Repeated with signed_mode=0: xgy=1.
- Also x=8'hFF, y=8'hFE, signed_mode=1: xgy=1, ndig=4.
REQ-035 Protocol: start held high through RUN with x/y changed every cycle.
- Required: only the operands at the accepted start are used; exactly one done per accepted start.
- A start in the DONE cycle begins a new RUN in cycle n+k+2.
REQ-036 Reset mid-operation: x=8'h3C, y=8'h3D, start, then rst=1 in cycle n+2.
- Required: in cycle n+3 busy=0, done=0, flags=0, ndig=0; no later done pulse.
REQ-037 Exhaustive: WIDTH=4 with DIGIT in {1,2,4}, all 256 x/y pairs, both modes, checked against a behavioural model.
- Required: flags and ndig match the model; done latency is ndig+1 cycles.
